// File: rtl/frame_checker_mc_if.sv
// AXI-stream sink bundle for frame_checker_mc: valid/ready handshake plus data, keep, id, user and last.
interface frame_checker_mc_if #(
  parameter int unsigned DATA_BYTES = 64,
  parameter int unsigned NUM_CH     = 8
);
  localparam int unsigned ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    s_valid;
  logic                    s_ready;
  logic                    s_last;
  logic                    s_user;
  logic [8*DATA_BYTES-1:0] s_data;
  logic [DATA_BYTES-1:0]   s_keep;
  logic [ID_W-1:0]         s_id;

  modport master (output s_valid, s_last, s_user, s_data, s_keep, s_id, input s_ready);
  modport slave  (input s_valid, s_last, s_user, s_data, s_keep, s_id, output s_ready);
endinterface

// File: rtl/frame_checker_mc.sv
// Multi-channel AXIS frame checker: per-channel frame/byte/length/sequence counters, all saturating.
// Optional per-channel user-error counters are built when FRAME_CHECKER_USER_ERR_EN is defined.
module frame_checker_mc #(
  parameter int unsigned DATA_BYTES = 64,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned CNT_W      = 48,
  parameter int unsigned SEQ_OFFSET = 42
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [15:0]             expected_len,
  frame_checker_mc_if.slave       s,
  output logic [NUM_CH*CNT_W-1:0] res_frames,
  output logic [NUM_CH*CNT_W-1:0] res_bytes,
  output logic [NUM_CH*CNT_W-1:0] res_len_err,
  output logic [NUM_CH*CNT_W-1:0] res_seq_err,
  output logic [NUM_CH*CNT_W-1:0] res_user_err,
  output logic                    running
);
  localparam int unsigned ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned POP_W = $clog2(DATA_BYTES) + 1;
  localparam int unsigned SUM_W = ((CNT_W > 16) ? CNT_W : 16) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic             ready_q, running_q;
  logic             in_frame_q, cnt_q, chk_q;
  logic [ID_W-1:0]  ch_q;
  logic [31:0]      seq_q;
  logic [15:0]      len_acc_q;

  logic             pend_q, pend_chk_q, pend_len_err_q;
  logic [ID_W-1:0]  pend_ch_q;
  logic [31:0]      pend_seq_q;
  logic [15:0]      pend_len_q;

  logic [CNT_W-1:0] frames_q  [NUM_CH];
  logic [CNT_W-1:0] bytes_q   [NUM_CH];
  logic [CNT_W-1:0] len_err_q [NUM_CH];
  logic [CNT_W-1:0] seq_err_q [NUM_CH];
  logic [31:0]      exp_q     [NUM_CH];
  logic [NUM_CH-1:0] seq_valid_q;

  logic             beat, first_beat, frame_open;
  logic [POP_W-1:0] pop;
  logic [16:0]      len_sum;
  logic [15:0]      len_now;
  logic [31:0]      seq_in;
  logic             seq_chk_in;
  logic [ID_W-1:0]  cur_ch;
  logic [31:0]      cur_seq;
  logic             cur_chk, cur_cnt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [15:0] b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    return (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  assign beat       = s.s_valid && s.s_ready;
  assign first_beat = beat && !in_frame_q;
  // A frame is open after this cycle if the current beat is not last, or nothing arrives mid-frame.
  assign frame_open = beat ? !s.s_last : in_frame_q;
  assign s.s_ready  = ready_q;
  assign running    = running_q;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (stop) state_d = frame_open ? DRAIN : IDLE;
        DRAIN:   if (beat && s.s_last) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d != IDLE);
      ready_q   <= 1'b1;
    end
  end

  // Byte count, big-endian sequence field and its keep coverage for the current beat.
  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_BYTES; i++) pop = pop + POP_W'(s.s_keep[i]);
    seq_in = '0;
    for (int b = 0; b < 4; b++) seq_in[8*(3-b) +: 8] = s.s_data[8*(SEQ_OFFSET+b) +: 8];
  end

  assign seq_chk_in = &s.s_keep[SEQ_OFFSET +: 4];
  assign len_sum    = 17'(first_beat ? 16'd0 : len_acc_q) + 17'(pop);
  assign len_now    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign cur_ch     = first_beat ? s.s_id : ch_q;
  assign cur_seq    = first_beat ? seq_in : seq_q;
  assign cur_chk    = first_beat ? seq_chk_in : chk_q;
  assign cur_cnt    = first_beat ? (state_q == RUN) : cnt_q;

  // Per-frame tracking and the one-cycle commit stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_frame_q     <= 1'b0;
      cnt_q          <= 1'b0;
      chk_q          <= 1'b0;
      ch_q           <= '0;
      seq_q          <= '0;
      len_acc_q      <= '0;
      pend_q         <= 1'b0;
      pend_chk_q     <= 1'b0;
      pend_len_err_q <= 1'b0;
      pend_ch_q      <= '0;
      pend_seq_q     <= '0;
      pend_len_q     <= '0;
    end else begin
      if (beat) begin
        in_frame_q <= !s.s_last;
        len_acc_q  <= len_now;
        ch_q       <= cur_ch;
        seq_q      <= cur_seq;
        chk_q      <= cur_chk;
        cnt_q      <= cur_cnt && !start;
        pend_ch_q      <= cur_ch;
        pend_seq_q     <= cur_seq;
        pend_chk_q     <= cur_chk;
        pend_len_q     <= len_now;
        pend_len_err_q <= (len_now != expected_len);
      end else if (start) begin
        cnt_q <= 1'b0;
      end
      pend_q <= beat && s.s_last && cur_cnt && !start;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || start) begin
      for (int c = 0; c < NUM_CH; c++) begin
        frames_q[c]  <= '0;
        bytes_q[c]   <= '0;
        len_err_q[c] <= '0;
        seq_err_q[c] <= '0;
        exp_q[c]     <= '0;
      end
      seq_valid_q <= '0;
    end else if (pend_q) begin
      frames_q[pend_ch_q] <= sat_add(frames_q[pend_ch_q], 16'd1);
      bytes_q[pend_ch_q]  <= sat_add(bytes_q[pend_ch_q], pend_len_q);
      if (pend_len_err_q) len_err_q[pend_ch_q] <= sat_add(len_err_q[pend_ch_q], 16'd1);
      // First checked frame only arms the expectation; later ones compare and always resync.
      if (pend_chk_q) begin
        if (seq_valid_q[pend_ch_q] && (pend_seq_q != exp_q[pend_ch_q]))
          seq_err_q[pend_ch_q] <= sat_add(seq_err_q[pend_ch_q], 16'd1);
        exp_q[pend_ch_q]       <= pend_seq_q + 32'd1;
        seq_valid_q[pend_ch_q] <= 1'b1;
      end
    end
  end

  always_comb begin
    res_frames  = '0;
    res_bytes   = '0;
    res_len_err = '0;
    res_seq_err = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      res_frames[c*CNT_W +: CNT_W]  = frames_q[c];
      res_bytes[c*CNT_W +: CNT_W]   = bytes_q[c];
      res_len_err[c*CNT_W +: CNT_W] = len_err_q[c];
      res_seq_err[c*CNT_W +: CNT_W] = seq_err_q[c];
    end
  end

`ifdef FRAME_CHECKER_USER_ERR_EN
  logic             pend_user_q;
  logic [CNT_W-1:0] user_err_q [NUM_CH];
  logic             unused_sink;
  assign unused_sink = ^s.s_data;

  always_ff @(posedge clk) begin
    if (!rst) pend_user_q <= 1'b0;
    else if (beat) pend_user_q <= s.s_user;
  end

  always_ff @(posedge clk) begin
    if (!rst || start) begin
      for (int c = 0; c < NUM_CH; c++) user_err_q[c] <= '0;
    end else if (pend_q && pend_user_q) begin
      user_err_q[pend_ch_q] <= sat_add(user_err_q[pend_ch_q], 16'd1);
    end
  end

  always_comb begin
    res_user_err = '0;
    for (int c = 0; c < NUM_CH; c++) res_user_err[c*CNT_W +: CNT_W] = user_err_q[c];
  end
`else
  logic unused_sink;
  assign unused_sink  = ^{s.s_data, s.s_user};
  assign res_user_err = '0;
`endif
endmodule

// File: tb/tb_frame_checker_mc.sv
// Randomized self-checking bench: two checkers (48-bit counters / seq at 42, 4-bit counters / seq at 60)
// share one stimulus stream and are compared against a frame-level reference model.
module tb_frame_checker_mc;
  localparam int unsigned DB = 64;
  localparam int unsigned NC = 8;
  localparam int unsigned WA = 48;
  localparam int unsigned WB = 4;
`ifdef FRAME_CHECKER_USER_ERR_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, stop;
  logic [15:0] expected_len;
  always #5 clk = ~clk;

  frame_checker_mc_if #(.DATA_BYTES(DB), .NUM_CH(NC)) ifa ();
  frame_checker_mc_if #(.DATA_BYTES(DB), .NUM_CH(NC)) ifb ();

  logic [NC*WA-1:0] a_fr, a_by, a_le, a_se, a_ue;
  logic [NC*WB-1:0] b_fr, b_by, b_le, b_se, b_ue;
  logic a_run, b_run;

  frame_checker_mc #(.DATA_BYTES(DB), .NUM_CH(NC), .CNT_W(WA), .SEQ_OFFSET(42)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .expected_len(expected_len), .s(ifa),
    .res_frames(a_fr), .res_bytes(a_by), .res_len_err(a_le), .res_seq_err(a_se),
    .res_user_err(a_ue), .running(a_run));

  frame_checker_mc #(.DATA_BYTES(DB), .NUM_CH(NC), .CNT_W(WB), .SEQ_OFFSET(60)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .expected_len(expected_len), .s(ifb),
    .res_frames(b_fr), .res_bytes(b_by), .res_len_err(b_le), .res_seq_err(b_se),
    .res_user_err(b_ue), .running(b_run));

  int total, bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Reference model: [instance][field][channel], fields frames/bytes/len_err/seq_err/user_err.
  longint unsigned m_cnt [2][5][NC];
  bit              m_sv  [2][NC];
  logic [31:0]     m_exp [2][NC];
  bit              m_active;
  int unsigned     nxt   [NC];

  function automatic int off(input int i);
    return (i == 0) ? 42 : 60;
  endfunction

  function automatic longint unsigned cmax(input int i);
    return (i == 0) ? ((64'd1 << WA) - 64'd1) : ((64'd1 << WB) - 64'd1);
  endfunction

  function automatic longint unsigned sadd(input int i, input longint unsigned a, input longint unsigned b);
    return (a + b > cmax(i)) ? cmax(i) : a + b;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NC; c++) begin
        for (int f = 0; f < 5; f++) m_cnt[i][f][c] = 0;
        m_sv[i][c]  = 1'b0;
        m_exp[i][c] = '0;
      end
  endfunction

  function automatic void m_frame(input int ch, input int nbytes, input logic [31:0] seq, input bit user);
    longint unsigned len;
    len = (nbytes > 65535) ? 65535 : longint'(nbytes);
    for (int i = 0; i < 2; i++) begin
      m_cnt[i][0][ch] = sadd(i, m_cnt[i][0][ch], 1);
      m_cnt[i][1][ch] = sadd(i, m_cnt[i][1][ch], len);
      if (len != 64'(expected_len)) m_cnt[i][2][ch] = sadd(i, m_cnt[i][2][ch], 1);
      if (nbytes >= off(i) + 4) begin
        if (m_sv[i][ch] && seq != m_exp[i][ch]) m_cnt[i][3][ch] = sadd(i, m_cnt[i][3][ch], 1);
        m_exp[i][ch] = seq + 32'd1;
        m_sv[i][ch]  = 1'b1;
      end
      if (USER_EN && user) m_cnt[i][4][ch] = sadd(i, m_cnt[i][4][ch], 1);
    end
  endfunction

  function automatic string fname(input int f);
    case (f)
      0: return "frames";
      1: return "bytes";
      2: return "len_err";
      3: return "seq_err";
      default: return "user_err";
    endcase
  endfunction

  function automatic logic [63:0] act(input int i, input int f, input int c);
    logic [NC*WA-1:0] v;
    int w;
    w = (i == 0) ? WA : WB;
    case (f)
      0: v = (i == 0) ? a_fr : (NC*WA)'(b_fr);
      1: v = (i == 0) ? a_by : (NC*WA)'(b_by);
      2: v = (i == 0) ? a_le : (NC*WA)'(b_le);
      3: v = (i == 0) ? a_se : (NC*WA)'(b_se);
      default: v = (i == 0) ? a_ue : (NC*WA)'(b_ue);
    endcase
    return 64'((v >> (c * w)) & (((NC*WA)'(1) << w) - (NC*WA)'(1)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    repeat (2) tick();
    for (int i = 0; i < 2; i++)
      for (int f = 0; f < 5; f++)
        for (int c = 0; c < NC; c++)
          check($sformatf("%s %s.%s[%0d]", tag, (i == 0) ? "a" : "b", fname(f), c),
                act(i, f, c), m_cnt[i][f][c]);
  endtask

  task automatic drive_beat(input logic [8*DB-1:0] d, input logic [DB-1:0] k, input logic [2:0] id,
                            input bit last, input bit user, input bit stp);
    ifa.s_valid = 1'b1; ifa.s_data = d; ifa.s_keep = k; ifa.s_id = id; ifa.s_last = last; ifa.s_user = user;
    ifb.s_valid = 1'b1; ifb.s_data = d; ifb.s_keep = k; ifb.s_id = id; ifb.s_last = last; ifb.s_user = user;
    stop = stp;
    tick();
    ifa.s_valid = 1'b0;
    ifb.s_valid = 1'b0;
    stop = 1'b0;
  endtask

  task automatic send_frame(input int ch, input int nbytes, input logic [31:0] seq, input bit user,
                            input int stop_beat, input int max_gap, input bit lat);
    int nb;
    bit counted;
    nb = (nbytes + DB - 1) / DB;
    counted = m_active;
    for (int b = 0; b < nb; b++) begin
      logic [8*DB-1:0] d;
      logic [DB-1:0]   k;
      int              rem;
      for (int w = 0; w < DB / 4; w++) d[32*w +: 32] = $urandom;
      if (b == 0)
        for (int j = 0; j < 4; j++) begin
          d[8*(42+j) +: 8] = seq[8*(3-j) +: 8];
          d[8*(60+j) +: 8] = seq[8*(3-j) +: 8];
        end
      rem = nbytes - DB * b;
      k = (rem >= DB) ? '1 : (DB'(1) << rem) - DB'(1);
      repeat ($urandom_range(max_gap, 0)) tick();
      drive_beat(d, k, (b == 0) ? 3'(ch) : 3'($urandom_range(NC - 1, 0)), b == nb - 1,
                 (b == nb - 1) ? user : 1'($urandom_range(1, 0)), b == stop_beat);
      if (stop_beat >= 0 && b >= stop_beat) begin
        check($sformatf("drain a.running beat%0d", b), 64'(a_run), 64'(b < nb - 1));
        check($sformatf("drain b.running beat%0d", b), 64'(b_run), 64'(b < nb - 1));
      end
    end
    if (lat && counted) check("latency a.frames before", act(0, 0, ch), m_cnt[0][0][ch]);
    if (counted) m_frame(ch, nbytes, seq, user);
    if (lat && counted) begin
      tick();
      check("latency a.frames after", act(0, 0, ch), m_cnt[0][0][ch]);
    end
    if (stop_beat >= 0) m_active = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_clear();
    m_active = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    check("reset a.s_ready", 64'(ifa.s_ready), 64'd0);
    check("reset b.s_ready", 64'(ifb.s_ready), 64'd0);
    check("reset a.running", 64'(a_run), 64'd0);
    check("reset b.running", 64'(b_run), 64'd0);
    m_clear();
    m_active = 1'b0;
    check_all("reset");
    rst = 1'b1;
    tick();
    check("post-reset a.s_ready", 64'(ifa.s_ready), 64'd1);
    check("post-reset b.s_ready", 64'(ifb.s_ready), 64'd1);
  endtask

  initial begin
    logic [8*DB-1:0] d;
    int ch, len;
    logic [31:0] seq;
    total = 0; bad = 0;
    rst = 1'b0; start = 1'b0; stop = 1'b0; expected_len = 16'd100;
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_keep = '0; ifa.s_id = '0; ifa.s_last = 1'b0; ifa.s_user = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_keep = '0; ifb.s_id = '0; ifb.s_last = 1'b0; ifb.s_user = 1'b0;
    for (int c = 0; c < NC; c++) nxt[c] = 0;
    m_clear();
    m_active = 1'b0;

    do_reset();
    do_start();
    for (int s = 0; s < 4; s++) send_frame(2, 100, 32'(s), 1'b0, -1, 0, s == 0);
    check_all("seq0_3");

    send_frame(1, 100, 32'd5, 1'b0, -1, 1, 1'b0);
    send_frame(1, 100, 32'd6, 1'b0, -1, 1, 1'b0);
    send_frame(1, 100, 32'd8, 1'b0, -1, 1, 1'b0);
    send_frame(1, 100, 32'd9, 1'b0, -1, 1, 1'b0);
    send_frame(3, 100, 32'hFFFF_FFFF, 1'b0, -1, 1, 1'b0);
    send_frame(3, 100, 32'd0, 1'b0, -1, 1, 1'b0);
    check_all("seqerr_wrap");

    send_frame(4, 99, 32'd0, 1'b0, -1, 0, 1'b0);
    send_frame(1, 60, 32'd77, 1'b0, -1, 0, 1'b0);
    send_frame(1, 60, 32'd78, 1'b0, -1, 0, 1'b0);
    check_all("len_keep");

    for (int n = 0; n < 40; n++) begin
      if (n == 20) expected_len = 16'd64;
      ch  = int'($urandom_range(NC - 1, 0));
      case ($urandom_range(3, 0))
        0: len = int'(expected_len);
        1: len = 64;
        2: len = 45 + int'($urandom_range(1, 0));
        default: len = int'($urandom_range(200, 1));
      endcase
      seq = ($urandom_range(4, 0) == 0) ? 32'($urandom) : 32'(nxt[ch]);
      nxt[ch] = seq + 32'd1;
      send_frame(ch, len, seq, 1'($urandom_range(1, 0)), -1, 2, 1'b0);
    end
    check_all("random");

    expected_len = 16'd150;
    send_frame(6, 150, 32'(nxt[6]), 1'b0, 1, 1, 1'b0);
    send_frame(6, 150, 32'd500, 1'b0, -1, 0, 1'b0);
    send_frame(2, 30, 32'd7, 1'b0, -1, 0, 1'b0);
    check_all("drain");

    for (int w = 0; w < DB / 4; w++) d[32*w +: 32] = $urandom;
    drive_beat(d, '1, 3'd7, 1'b0, 1'b0, 1'b0);
    do_start();
    drive_beat(d, 64'h0000_0000_0000_00FF, 3'd7, 1'b1, 1'b0, 1'b0);
    send_frame(5, 150, 32'd1, 1'b0, -1, 0, 1'b0);
    check_all("idle_start");

    expected_len = 16'd8;
    for (int f = 0; f < 17; f++) send_frame(0, 8, 32'(f), (f == 3 || f == 7), -1, 0, 1'b0);
    check_all("saturate");

    drive_beat(d, '1, 3'd5, 1'b0, 1'b0, 1'b0);
    do_reset();
    do_start();
    expected_len = 16'd100;
    send_frame(5, 100, 32'd0, 1'b1, -1, 0, 1'b0);
    check_all("rst_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
